// File: rtl/rd_ctrl_pkg.sv
// Shared definitions for rd_burst_ctrl: FSM state encoding and sizing helpers.
// Widths derived here are used directly in the top-level port list.
package rd_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Burstcount must be able to hold BURST_LEN itself, hence the +1.
  function automatic int burst_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rd_burst_ctrl.sv
// Avalon-MM burst read master that copies a memory region into the capture FIFO.
// One outstanding burst; data to FIFO one cycle after readdatavalid; RD_CTRL_BSWAP_EN byte-reverses words.
module rd_burst_ctrl
  import rd_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int LEN_W     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [LEN_W-1:0]                  num_words,
  output logic                              rd_ctrl_rdy,
  output logic                              done,
  output logic [ADDR_W-1:0]                 avm_address,
  output logic                              avm_read,
  output logic [burst_w(BURST_LEN)-1:0]     avm_burstcount,
  input  logic                              avm_waitrequest,
  input  logic [DATA_W-1:0]                 avm_readdata,
  input  logic                              avm_readdatavalid,
  input  logic                              almost_full,
  output logic                              fifo_wr,
  output logic [DATA_W-1:0]                 fifo_in
);

  localparam int BURST_W = burst_w(BURST_LEN);
  localparam int BYTES   = bytes_per_word(DATA_W);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;
  logic [BURST_W-1:0]  beats_left;
  logic [BURST_W-1:0]  burst_cnt;
  logic                issued;
  logic                accept;
  logic                beat;
  logic [DATA_W-1:0]   rdata_sw;

`ifdef RD_CTRL_BSWAP_EN
  for (genvar g = 0; g < BYTES; g++) begin : g_bswap
    assign rdata_sw[8*g +: 8] = avm_readdata[8*(BYTES-1-g) +: 8];
  end
`else
  assign rdata_sw = avm_readdata;
`endif

  assign burst_cnt = (remaining >= LEN_W'(BURST_LEN)) ? BURST_W'(BURST_LEN)
                                                      : BURST_W'(remaining);

  // Once a request is on the bus it must stay there until accepted, so
  // almost_full only gates the first cycle of each request.
  assign avm_read       = (state == ST_REQ) && (issued || !almost_full);
  assign accept         = avm_read && !avm_waitrequest;
  assign beat           = (state == ST_DATA) && avm_readdatavalid;
  assign avm_address    = addr;
  assign avm_burstcount = burst_cnt;
  assign rd_ctrl_rdy    = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      beats_left <= '0;
      issued     <= 1'b0;
      done       <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_in    <= '0;
    end else begin
      done    <= (state == ST_DONE);
      fifo_wr <= beat;
      if (beat) fifo_in <= rdata_sw;

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= num_words;
            state     <= (num_words == '0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          issued <= avm_read && avm_waitrequest;
          if (accept) begin
            addr       <= addr + ADDR_W'(burst_cnt) * ADDR_W'(BYTES);
            beats_left <= burst_cnt;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beats_left <= beats_left - BURST_W'(1);
            remaining  <= remaining - LEN_W'(1);
            if (beats_left == BURST_W'(1))
              state <= (remaining != LEN_W'(1)) ? ST_REQ : ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
